// File: rtl/cr_osf_ob_arb_pkg.sv
// -----------------------------------------------------------------------------
// cr_osf_ob_arb_pkg
// Shared types for the OSF outbound arbiter slice:
//   axi4s_dp_bus_t  - AXI4-stream beat (tvalid, tdata, tstrb, tuser)
//                     tuser[0] = SOT, tuser[1] = EOT
//   axi4s_dp_rdy_t  - AXI4-stream back-channel (tready)
//   osf_ob_arb_st_e - arbiter frame-ownership states
// -----------------------------------------------------------------------------
package cr_osf_ob_arb_pkg;

  localparam int TDATA_W = 64;
  localparam int TSTRB_W = TDATA_W / 8;
  localparam int TUSER_W = 2;

  localparam int SOT_BIT = 0;
  localparam int EOT_BIT = 1;

  typedef struct packed {
    logic               tvalid;
    logic [TDATA_W-1:0] tdata;
    logic [TSTRB_W-1:0] tstrb;
    logic [TUSER_W-1:0] tuser;
  } axi4s_dp_bus_t;

  typedef struct packed {
    logic tready;
  } axi4s_dp_rdy_t;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } osf_ob_arb_st_e;

  // One-hot grant vector for a port index.
  function automatic logic [1:0] port_onehot(input logic port);
    return port ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/cr_osf_ob_arb_oreg.sv
// -----------------------------------------------------------------------------
// cr_osf_ob_arb_oreg
// One-entry output register slice for the outbound arbiter. Holds the beat
// presented downstream and tells the arbiter when a new beat may be loaded.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   load       - arbiter accepted a beat this cycle (only while can_load)
//   load_bus   - beat to capture (tdata/tstrb/tuser copied unmodified)
//   out_rdy    - downstream tready
//   can_load   - register empty or draining this cycle
//   out_bus    - registered output beat
// -----------------------------------------------------------------------------
module cr_osf_ob_arb_oreg
  import cr_osf_ob_arb_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  axi4s_dp_bus_t load_bus,
  input  axi4s_dp_rdy_t out_rdy,
  output logic          can_load,
  output axi4s_dp_bus_t out_bus
);

  axi4s_dp_bus_t out_d;
  axi4s_dp_bus_t out_q;

  assign can_load = !out_q.tvalid || out_rdy.tready;
  assign out_bus  = out_q;

  // Next register contents: a new beat replaces the old one, otherwise the
  // valid bit drops once downstream takes the beat and the payload is kept.
  always_comb begin
    out_d = out_q;
    if (load) begin
      out_d        = load_bus;
      out_d.tvalid = 1'b1;
    end else if (out_rdy.tready) begin
      out_d.tvalid = 1'b0;
    end
  end

  // Reset discards any in-flight beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

endmodule

// File: rtl/cr_osf_ob_arb.sv
// -----------------------------------------------------------------------------
// cr_osf_ob_arb
// Frame-atomic two-port arbiter sharing the OSF outbound AXI4-stream between
// the data-frame path (port 0) and the CQE/control-frame path (port 1). A port
// keeps the grant from its frame-start beat until its EOT beat is accepted.
// Configuration macro: CR_OSF_OB_ARB_PRIO_EN
//   defined   - port 1 wins every IDLE conflict
//   undefined - round-robin on conflicts (winner is the port != last_port)
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   in0_bus/in0_rdy   - port 0 stream and its tready
//   in1_bus/in1_rdy   - port 1 stream and its tready
//   out_bus/out_rdy   - registered arbitrated stream and downstream tready
//   grant             - one-hot current owner (IDLE: current winner or 0)
//   frame_done_stb    - pulse one cycle after an EOT beat is accepted
//   frame_done_port   - port of the completed frame (valid with strobe)
//   frame_beats       - saturating beat count of that frame (valid with strobe)
//   arb_conflict_stb  - both ports presented SOT while IDLE
//   sot_err_stb       - a frame was started by a beat without SOT
// -----------------------------------------------------------------------------
module cr_osf_ob_arb
  import cr_osf_ob_arb_pkg::*;
#(
  parameter int FRM_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  axi4s_dp_bus_t        in0_bus,
  output axi4s_dp_rdy_t        in0_rdy,
  input  axi4s_dp_bus_t        in1_bus,
  output axi4s_dp_rdy_t        in1_rdy,
  output axi4s_dp_bus_t        out_bus,
  input  axi4s_dp_rdy_t        out_rdy,
  output logic [1:0]           grant,
  output logic                 frame_done_stb,
  output logic                 frame_done_port,
  output logic [FRM_CNT_W-1:0] frame_beats,
  output logic                 arb_conflict_stb,
  output logic                 sot_err_stb
);

  localparam logic [FRM_CNT_W-1:0] CNT_ONE = FRM_CNT_W'(1);

  osf_ob_arb_st_e       state_q, state_d;
  logic                 last_port_q, last_port_d;
  logic [FRM_CNT_W-1:0] cnt_q, cnt_d;
  logic                 frame_done_stb_q, frame_done_stb_d;
  logic                 frame_done_port_q, frame_done_port_d;
  logic [FRM_CNT_W-1:0] frame_beats_q, frame_beats_d;
  logic                 arb_conflict_stb_q, arb_conflict_stb_d;
  logic                 sot_err_stb_q, sot_err_stb_d;

  logic                 can_load;
  logic                 conflict_winner;
  logic [1:0]           gnt;
  logic                 sel_port;
  axi4s_dp_bus_t        sel_bus;
  logic                 accept;
  logic                 is_idle;
  logic                 frame_start;
  logic                 beat_eot;
  logic                 both_req;

  assign both_req = in0_bus.tvalid && in1_bus.tvalid;
  assign is_idle  = (state_q == ARB_IDLE);

`ifdef CR_OSF_OB_ARB_PRIO_EN
  // CQE path always wins a tie; last_port is kept up to date but not consulted.
  assign conflict_winner = 1'b1;
`else
  assign conflict_winner = ~last_port_q;
`endif

  // Grant selection: the owner is fixed while a frame is open; in IDLE the
  // winner is decided combinationally so its beat can be taken this cycle.
  always_comb begin
    gnt = 2'b00;
    unique case (state_q)
      ARB_OWN0: gnt = 2'b01;
      ARB_OWN1: gnt = 2'b10;
      default: begin
        if (both_req) begin
          gnt = port_onehot(conflict_winner);
        end else if (in0_bus.tvalid) begin
          gnt = 2'b01;
        end else if (in1_bus.tvalid) begin
          gnt = 2'b10;
        end
      end
    endcase
  end

  assign sel_port    = gnt[1];
  assign sel_bus     = sel_port ? in1_bus : in0_bus;
  assign accept      = can_load && ((gnt[0] && in0_bus.tvalid) ||
                                    (gnt[1] && in1_bus.tvalid));
  assign frame_start = accept && is_idle;
  assign beat_eot    = sel_bus.tuser[EOT_BIT];

  assign in0_rdy.tready = gnt[0] && can_load;
  assign in1_rdy.tready = gnt[1] && can_load;
  assign grant          = gnt;

  // Next-state, round-robin history, beat counter and the registered stats
  // strobes. Nothing moves unless a beat is accepted, so a stalled output
  // freezes the whole frame bookkeeping.
  always_comb begin
    state_d            = state_q;
    last_port_d        = last_port_q;
    cnt_d              = cnt_q;
    frame_done_stb_d   = 1'b0;
    frame_done_port_d  = frame_done_port_q;
    frame_beats_d      = frame_beats_q;
    arb_conflict_stb_d = is_idle && can_load && both_req &&
                         in0_bus.tuser[SOT_BIT] && in1_bus.tuser[SOT_BIT];
    sot_err_stb_d      = frame_start && !sel_bus.tuser[SOT_BIT];

    if (frame_start) begin
      cnt_d       = CNT_ONE;
      last_port_d = sel_port;
    end else if (accept) begin
      cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;
    end

    if (accept) begin
      if (beat_eot) begin
        state_d           = ARB_IDLE;
        frame_done_stb_d  = 1'b1;
        frame_done_port_d = sel_port;
        frame_beats_d     = cnt_d;
      end else if (is_idle) begin
        state_d = sel_port ? ARB_OWN1 : ARB_OWN0;
      end
    end
  end

  // All arbiter state and stats outputs; reset abandons any partial frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q            <= ARB_IDLE;
      last_port_q        <= 1'b1;
      cnt_q              <= '0;
      frame_done_stb_q   <= 1'b0;
      frame_done_port_q  <= 1'b0;
      frame_beats_q      <= '0;
      arb_conflict_stb_q <= 1'b0;
      sot_err_stb_q      <= 1'b0;
    end else begin
      state_q            <= state_d;
      last_port_q        <= last_port_d;
      cnt_q              <= cnt_d;
      frame_done_stb_q   <= frame_done_stb_d;
      frame_done_port_q  <= frame_done_port_d;
      frame_beats_q      <= frame_beats_d;
      arb_conflict_stb_q <= arb_conflict_stb_d;
      sot_err_stb_q      <= sot_err_stb_d;
    end
  end

  assign frame_done_stb   = frame_done_stb_q;
  assign frame_done_port  = frame_done_port_q;
  assign frame_beats      = frame_beats_q;
  assign arb_conflict_stb = arb_conflict_stb_q;
  assign sot_err_stb      = sot_err_stb_q;

  cr_osf_ob_arb_oreg u_oreg (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_bus (sel_bus),
    .out_rdy  (out_rdy),
    .can_load (can_load),
    .out_bus  (out_bus)
  );

endmodule

// File: tb/tb_cr_osf_ob_arb.sv
// -----------------------------------------------------------------------------
// tb_cr_osf_ob_arb
// Directed self-checking bench for cr_osf_ob_arb. Inputs change 1 time unit
// after the rising edge; outputs are observed on the falling edge.
// Build with CR_OSF_OB_ARB_PRIO_EN defined to check the strict-priority mode.
// -----------------------------------------------------------------------------
module tb_cr_osf_ob_arb;
  import cr_osf_ob_arb_pkg::*;

  localparam int FRM_CNT_W = 16;

  logic                 clk;
  logic                 rst;
  axi4s_dp_bus_t        in0_bus;
  axi4s_dp_rdy_t        in0_rdy;
  axi4s_dp_bus_t        in1_bus;
  axi4s_dp_rdy_t        in1_rdy;
  axi4s_dp_bus_t        out_bus;
  axi4s_dp_rdy_t        out_rdy;
  logic [1:0]           grant;
  logic                 frame_done_stb;
  logic                 frame_done_port;
  logic [FRM_CNT_W-1:0] frame_beats;
  logic                 arb_conflict_stb;
  logic                 sot_err_stb;

  int compareCnt  = 0;
  int mismatchCnt = 0;
  int cyc         = 0;

  logic [63:0] outData[$];
  logic [1:0]  outUser[$];
  int          outCyc[$];
  logic        donePort[$];
  logic [15:0] doneBeats[$];
  logic [1:0]  grantLog[$];
  int          conflictCnt;
  int          sotErrCnt;

  cr_osf_ob_arb #(.FRM_CNT_W(FRM_CNT_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .in0_bus          (in0_bus),
    .in0_rdy          (in0_rdy),
    .in1_bus          (in1_bus),
    .in1_rdy          (in1_rdy),
    .out_bus          (out_bus),
    .out_rdy          (out_rdy),
    .grant            (grant),
    .frame_done_stb   (frame_done_stb),
    .frame_done_port  (frame_done_port),
    .frame_beats      (frame_beats),
    .arb_conflict_stb (arb_conflict_stb),
    .sot_err_stb      (sot_err_stb)
  );

  // Free-running clock and cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Passive monitor: logs delivered beats, stats strobes and the grant seen
  // on every input handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_bus.tvalid && out_rdy.tready) begin
        outData.push_back(out_bus.tdata);
        outUser.push_back(out_bus.tuser);
        outCyc.push_back(cyc);
      end
      if (frame_done_stb) begin
        donePort.push_back(frame_done_port);
        doneBeats.push_back(frame_beats);
      end
      if (arb_conflict_stb) conflictCnt++;
      if (sot_err_stb) sotErrCnt++;
      if ((in0_rdy.tready && in0_bus.tvalid) || (in1_rdy.tready && in1_bus.tvalid))
        grantLog.push_back(grant);
    end
  end

  // Hard stop in case something wedges outside the per-beat bounds.
  initial begin
    repeat (95000) @(posedge clk);
    $display("[TB] FAIL watchdog: got %0d cycles, required fewer than 95000", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [95:0] observed,
                             input logic [95:0] expected);
    compareCnt++;
    if (observed !== expected) begin
      mismatchCnt++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic clearLogs();
    outData.delete();
    outUser.delete();
    outCyc.delete();
    donePort.delete();
    doneBeats.delete();
    grantLog.delete();
    conflictCnt = 0;
    sotErrCnt   = 0;
  endtask

  // Leaves the bench at posedge+1 with reset released and logs empty.
  task automatic doReset();
    rst     = 1'b1;
    in0_bus = '0;
    in1_bus = '0;
    out_rdy = '{tready: 1'b1};
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    clearLogs();
  endtask

  task automatic drain();
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Sends one frame on a port, waiting for each beat's handshake. Beat i
  // carries tdata = base + i; SOT on beat 0 when sotFirst, or on beat midSot.
  task automatic applyStimulus(input int port, input int nBeats,
                               input logic [63:0] base, input bit sotFirst,
                               input int midSot);
    axi4s_dp_bus_t b;
    logic          acc;
    int            waitCnt;
    for (int i = 0; i < nBeats; i++) begin
      b.tvalid = 1'b1;
      b.tdata  = base + 64'(i);
      b.tstrb  = 8'hFF;
      b.tuser  = {(i == nBeats - 1), ((i == 0) && sotFirst) || (i == midSot)};
      if (port == 0) in0_bus = b; else in1_bus = b;
      acc     = 1'b0;
      waitCnt = 0;
      while (!acc) begin
        @(negedge clk);
        acc = (port == 0) ? in0_rdy.tready : in1_rdy.tready;
        @(posedge clk);
        #1;
        waitCnt++;
        if (!acc && waitCnt > 500) begin
          checkOutput($sformatf("beatTimeout_p%0d", port), 0, 1);
          if (port == 0) in0_bus = '0; else in1_bus = '0;
          return;
        end
      end
    end
    if (port == 0) in0_bus.tvalid = 1'b0; else in1_bus.tvalid = 1'b0;
  endtask

  initial begin
    int          startCyc;
    int          waitCnt;
    logic [63:0] expData[8];
    logic        expPort[4];
    int          expConflicts;

    // ---------------- reset values ----------------
    rst     = 1'b1;
    in0_bus = '0;
    in1_bus = '0;
    out_rdy = '{tready: 1'b1};
    @(negedge clk);
    checkOutput("rst_out_bus", out_bus, 0);
    checkOutput("rst_grant", grant, 0);
    checkOutput("rst_done_stb", frame_done_stb, 0);
    checkOutput("rst_beats", frame_beats, 0);
    checkOutput("rst_conflict", arb_conflict_stb, 0);
    checkOutput("rst_soterr", sot_err_stb, 0);
    checkOutput("rst_in0_rdy", in0_rdy.tready, 0);
    doReset();

    // ---------------- single port, 4-beat frame ----------------
    startCyc = cyc;
    applyStimulus(0, 4, 64'h100, 1'b1, -1);
    drain();
    checkOutput("t1_nbeats", outData.size(), 4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("t1_data%0d", i), (i < outData.size()) ? outData[i] : 64'hx, 64'h100 + 64'(i));
      checkOutput($sformatf("t1_cyc%0d", i), (i < outCyc.size()) ? outCyc[i] : -1, startCyc + 1 + i);
      checkOutput($sformatf("t1_grant%0d", i), (i < grantLog.size()) ? grantLog[i] : 2'bxx, 2'b01);
    end
    checkOutput("t1_user0", (outUser.size() > 0) ? outUser[0] : 2'bxx, 2'b01);
    checkOutput("t1_user3", (outUser.size() > 3) ? outUser[3] : 2'bxx, 2'b10);
    checkOutput("t1_ndone", donePort.size(), 1);
    checkOutput("t1_done_port", (donePort.size() > 0) ? donePort[0] : 1'bx, 0);
    checkOutput("t1_done_beats", (doneBeats.size() > 0) ? doneBeats[0] : 16'hx, 4);
    checkOutput("t1_conflicts", conflictCnt, 0);

    // ---------------- simultaneous SOT ----------------
    doReset();
`ifdef CR_OSF_OB_ARB_PRIO_EN
    expData      = '{64'h300, 64'h301, 64'h310, 64'h311, 64'h200, 64'h201, 64'h210, 64'h211};
    expPort      = '{1'b1, 1'b1, 1'b0, 1'b0};
    expConflicts = 2;
`else
    expData      = '{64'h200, 64'h201, 64'h300, 64'h301, 64'h210, 64'h211, 64'h310, 64'h311};
    expPort      = '{1'b0, 1'b1, 1'b0, 1'b1};
    expConflicts = 3;
`endif
    fork
      begin
        applyStimulus(0, 2, 64'h200, 1'b1, -1);
        applyStimulus(0, 2, 64'h210, 1'b1, -1);
      end
      begin
        applyStimulus(1, 2, 64'h300, 1'b1, -1);
        applyStimulus(1, 2, 64'h310, 1'b1, -1);
      end
    join
    drain();
    checkOutput("t2_nbeats", outData.size(), 8);
    for (int i = 0; i < 8; i++)
      checkOutput($sformatf("t2_data%0d", i), (i < outData.size()) ? outData[i] : 64'hx, expData[i]);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("t2_port%0d", i), (i < donePort.size()) ? donePort[i] : 1'bx, expPort[i]);
      checkOutput($sformatf("t2_beats%0d", i), (i < doneBeats.size()) ? doneBeats[i] : 16'hx, 2);
    end
    checkOutput("t2_conflicts", conflictCnt, expConflicts);
    checkOutput("t2_soterr", sotErrCnt, 0);

    // ---------------- back-pressure with mid-frame SOT ----------------
    doReset();
    fork
      applyStimulus(0, 5, 64'h400, 1'b1, 2);
      begin
        waitCnt = 0;
        do begin
          @(posedge clk);
          #1;
          waitCnt++;
        end while (outData.size() < 2 && waitCnt < 200);
        checkOutput("t3_reach_stall", outData.size() >= 2, 1);
        out_rdy.tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          checkOutput($sformatf("t3_hold_data%0d", i), out_bus.tdata, 64'h402);
          checkOutput($sformatf("t3_hold_valid%0d", i), out_bus.tvalid, 1);
          checkOutput($sformatf("t3_in0_rdy%0d", i), in0_rdy.tready, 0);
        end
        @(posedge clk);
        #1 out_rdy.tready = 1'b1;
      end
    join
    drain();
    checkOutput("t3_nbeats", outData.size(), 5);
    for (int i = 0; i < 5; i++)
      checkOutput($sformatf("t3_data%0d", i), (i < outData.size()) ? outData[i] : 64'hx, 64'h400 + 64'(i));
    checkOutput("t3_mid_sot_user", (outUser.size() > 2) ? outUser[2] : 2'bxx, 2'b01);
    checkOutput("t3_soterr", sotErrCnt, 0);
    checkOutput("t3_done_beats", (doneBeats.size() > 0) ? doneBeats[0] : 16'hx, 5);

    // ---------------- single-beat frame ----------------
    doReset();
    applyStimulus(1, 1, 64'h550, 1'b1, -1);
    drain();
    @(negedge clk);
    checkOutput("t4_grant_idle", grant, 2'b00);
    checkOutput("t4_data", (outData.size() > 0) ? outData[0] : 64'hx, 64'h550);
    checkOutput("t4_done_port", (donePort.size() > 0) ? donePort[0] : 1'bx, 1);
    checkOutput("t4_done_beats", (doneBeats.size() > 0) ? doneBeats[0] : 16'hx, 1);

    // ---------------- frame start without SOT ----------------
    doReset();
    applyStimulus(0, 2, 64'h560, 1'b0, -1);
    drain();
    checkOutput("t5_soterr", sotErrCnt, 1);
    checkOutput("t5_nbeats", outData.size(), 2);
    checkOutput("t5_data0", (outData.size() > 0) ? outData[0] : 64'hx, 64'h560);
    checkOutput("t5_user0", (outUser.size() > 0) ? outUser[0] : 2'bxx, 2'b00);
    checkOutput("t5_done_beats", (doneBeats.size() > 0) ? doneBeats[0] : 16'hx, 2);

    // ---------------- reset mid-frame ----------------
    doReset();
    in0_bus = '{tvalid: 1'b1, tdata: 64'h600, tstrb: 8'hFF, tuser: 2'b01};
    @(posedge clk);
    #1 in0_bus.tdata = 64'h601;
    in0_bus.tuser = 2'b00;
    @(posedge clk);
    #1 in0_bus.tdata = 64'h602;
    #1 rst = 1'b1;
    in0_bus = '0;
    @(negedge clk);
    checkOutput("t6_out_bus", out_bus, 0);
    checkOutput("t6_grant", grant, 0);
    checkOutput("t6_done_stb", frame_done_stb, 0);
    checkOutput("t6_in0_rdy", in0_rdy.tready, 0);
    checkOutput("t6_in1_rdy", in1_rdy.tready, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    clearLogs();
    applyStimulus(1, 2, 64'h700, 1'b1, -1);
    drain();
    checkOutput("t6_nbeats", outData.size(), 2);
    checkOutput("t6_data0", (outData.size() > 0) ? outData[0] : 64'hx, 64'h700);
    checkOutput("t6_data1", (outData.size() > 1) ? outData[1] : 64'hx, 64'h701);
    checkOutput("t6_grant", (grantLog.size() > 0) ? grantLog[0] : 2'bxx, 2'b10);
    checkOutput("t6_ndone", donePort.size(), 1);
    checkOutput("t6_done_port", (donePort.size() > 0) ? donePort[0] : 1'bx, 1);
    checkOutput("t6_done_beats", (doneBeats.size() > 0) ? doneBeats[0] : 16'hx, 2);

    // ---------------- counter saturation ----------------
    doReset();
    applyStimulus(0, 70000, 64'h10000, 1'b1, -1);
    drain();
    checkOutput("t7_nbeats", outData.size(), 70000);
    checkOutput("t7_last", (outData.size() > 0) ? outData[outData.size() - 1] : 64'hx, 64'h10000 + 64'd69999);
    checkOutput("t7_done_beats", (doneBeats.size() > 0) ? doneBeats[0] : 16'hx, 16'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCnt, mismatchCnt);
    $finish;
  end

endmodule

// File: doc/cr_osf_ob_arb.md
# cr_osf_ob_arb

Frame-atomic two-port arbiter that shares the OSF outbound AXI4-stream between the data-frame path (port 0) and the CQE/control-frame path (port 1). It grants one port at a time and holds the grant until that frame's EOT beat has been accepted. It drives a single registered output stage towards the outbound FIFO and AXI master. It also emits per-frame strobes and beat counts for the OSF stats block.

## Interface

**Parameters**
- `FRM_CNT_W`, default 16: width of the per-frame beat counter.

**Ports**
- `clk` input 1: clock.
- `rst` input 1: reset, asynchronous, active-high.
- `in0_bus` input `axi4s_dp_bus_t`: port 0 stream. `tuser[0]` = SOT, `tuser[1]` = EOT.
- `in0_rdy` output `axi4s_dp_rdy_t`: port 0 tready.
- `in1_bus` input `axi4s_dp_bus_t`: port 1 stream.
- `in1_rdy` output `axi4s_dp_rdy_t`: port 1 tready.
- `out_bus` output `axi4s_dp_bus_t`: arbitrated stream, registered.
- `out_rdy` input `axi4s_dp_rdy_t`: downstream tready.
- `grant` output 2: one-hot current owner. 0 while IDLE with no winner.
- `frame_done_stb` output 1: 1-cycle pulse when an EOT beat is accepted from an input.
- `frame_done_port` output 1: port that completed the frame. Valid with the strobe.
- `frame_beats` output `FRM_CNT_W`: beats in the completed frame, saturating. Valid with the strobe.
- `arb_conflict_stb` output 1: both ports presented SOT while IDLE.
- `sot_err_stb` output 1: a frame was started by a beat without SOT.

## Operation

**State machine:** `ARB_IDLE`, `ARB_OWN0`, `ARB_OWN1`.

**ARB_IDLE**
- A port requests when its `tvalid` = 1.
- Single requester: that port wins.
- Both request: winner selection depends on the configuration macro (see Configuration).
- The winner's beat is accepted in the same cycle if the output stage can take it.
- Accepted beat without EOT: go to `ARB_OWNx`.
- Accepted beat with EOT (single-beat frame): stay in `ARB_IDLE`.
- Winner beat has SOT = 0: accept it anyway as a frame start and pulse `sot_err_stb`.

**ARB_OWNx**
- Only port x is eligible. The other port's tready = 0.
- Accepted beat with EOT: go to `ARB_IDLE`.
- SOT on a mid-frame beat is passed through unchanged. No error is flagged.

**Handshake**
- `can_load = !out_valid_q || out_rdy.tready`.
- Granted port's tready = `can_load`. Non-granted port's tready = 0.
- A beat is accepted when tvalid && tready. The output register then loads tdata, tstrb and tuser unmodified.
- Output valid clears on `out_rdy.tready` when no new beat loads.

**Round-robin**
- `last_port` register updates on every accepted SOT-start.
- Reset value is 1, so port 0 wins the first conflict.

**Beat counter**
- Set to 1 on a frame-start accept and incremented on each later accept.
- Saturates at 2^FRM_CNT_W − 1.
- On the EOT accept, `frame_beats` is the count including the EOT beat.

## Timing

- Input-accept to `out_bus.tvalid`: 1 cycle.
- Full throughput: 1 beat/cycle when `out_rdy.tready` is held at 1.
- No bubble between frames: the cycle after an EOT accept can accept the next SOT from either port.
- `frame_done_stb`, `frame_done_port`, `frame_beats`, `arb_conflict_stb` and `sot_err_stb` are registered and appear 1 cycle after the triggering accept or evaluation.
- Output stalled (`out_valid_q` = 1, `tready` = 0): no accept, state and counters hold, and `out_bus` holds stable.
- Reset values: all outputs 0, `out_bus` all-zero, state `ARB_IDLE`, `last_port` = 1, counter 0.
- Reset mid-frame: the partial frame is abandoned immediately, and any in-flight output beat is discarded.

## Configuration

- `CR_OSF_OB_ARB_PRIO_EN` defined: port 1 (CQE) has strict priority on conflicts in `ARB_IDLE`. `last_port` is still maintained but is unused.
- `CR_OSF_OB_ARB_PRIO_EN` undefined: round-robin on conflicts. The winner is the port ≠ `last_port`.
- No other behaviour differs.

## Structure

- `cr_osfPKG`: add the `osf_ob_arb_st_e` enum for the three states.
- `cr_structs`: reused unchanged for `axi4s_dp_bus_t` and `axi4s_dp_rdy_t`.
- Sub-module `cr_osf_ob_arb_oreg`: a one-entry output register slice holding the output valid/data register and its `can_load` logic. The FSM and counters stay in the top module.

## Test plan

- **Single port, continuous:** port 0 sends a 4-beat frame (SOT on beat 0, EOT on beat 3), with `tready` = 1. Expect 4 output beats at cycles +1 to +4, `frame_done_stb` with port 0 and `frame_beats` = 4, and `grant` = 01 during the frame.
- **Simultaneous SOT, round-robin build:** both ports present 2-beat frames continuously. Expect order P0, P1, P0, P1, a pulse on `arb_conflict_stb` each time, and no interleaving within a frame.
- **Simultaneous SOT, `CR_OSF_OB_ARB_PRIO_EN` build:** same stimulus. Expect P1 frames to win every conflict, with P0 advancing only while P1 is idle.
- **Back-pressure:** `out_rdy.tready` = 0 for 5 cycles mid-frame. Expect `out_bus` stable, input tready = 0, and no beat lost or duplicated after release.
- **Boundary cases:**
  - Single-beat frame (SOT = EOT = 1): state stays `ARB_IDLE` and `frame_beats` = 1.
  - 70000-beat frame with `FRM_CNT_W` = 16: `frame_beats` = 65535.
  - Beat with SOT = 0 while IDLE: `sot_err_stb` pulses and the beat passes through.
- **Reset mid-frame:** assert `rst` on beat 2 of 5. Expect all outputs 0 and state `ARB_IDLE`. The next P1 SOT is then accepted normally.
